fir_mac_scheduler: RTL

Time-multiplexed FIR filter controller. It accepts one input sample per handshake and shifts it into a local delay line. It then sequences a single shared multiply-accumulate unit across all FIR_order+1 taps, one tap per clock, and presents the result on a valid/ready output port. Coefficients are loaded at run time through a write port. The block sits between the sample source and the filter-output consumer. It is the area-minimal alternative to the fully parallel and pipelined FIR datapaths.

---
 rtl/fir_mac_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: one shared multiply-accumulate stepped across all taps,
// one tap per clock, with a run-time loadable coefficient bank and valid/ready result port.
module fir_mac_scheduler #(
  parameter int unsigned FIR_order     = 6,
  parameter int unsigned sample_size   = 4,
  parameter int unsigned weight_size   = 5,
  parameter int unsigned word_size_out = sample_size + weight_size + 3,
  parameter int unsigned addr_size     = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [sample_size-1:0]   sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     coef_wr_en,
  input  logic [addr_size-1:0]     coef_addr,
  input  logic [weight_size-1:0]   coef_data,
  output logic [word_size_out-1:0] fir_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int unsigned ProdW = sample_size + weight_size;
  localparam logic [addr_size-1:0] LastTap = addr_size'(FIR_order);

  typedef enum logic [1:0] {StIdle, StMac, StHold} state_e;

  state_e                   state_q, state_d;
  logic [sample_size-1:0]   x_q [FIR_order+1];
  logic [weight_size-1:0]   w_q [FIR_order+1];
  logic [word_size_out-1:0] acc_q;
  logic [addr_size-1:0]     tap_q;
  logic [word_size_out-1:0] fir_out_q;
  logic                     out_valid_q;

  logic                     accept;
  logic                     mac_last;
  logic                     coef_we;
  logic [ProdW-1:0]         prod;
  logic [word_size_out-1:0] mac_sum;

  always_comb begin
    state_d      = state_q;
    sample_ready = 1'b0;
    accept       = 1'b0;
    mac_last     = 1'b0;
    unique case (state_q)
      StIdle: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          accept  = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        if (tap_q == LastTap) begin
          mac_last = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Out-of-range addresses are dropped so they can never alias onto a real tap.
  assign coef_we = (state_q == StIdle) && coef_wr_en && (coef_addr <= LastTap);

  always_comb begin
    prod    = ProdW'(w_q[tap_q]) * ProdW'(x_q[tap_q]);
    mac_sum = acc_q + word_size_out'(prod);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k <= FIR_order; k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
      end
      acc_q       <= '0;
      tap_q       <= '0;
      fir_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q[0] <= sample_in;
        for (int unsigned k = 1; k <= FIR_order; k++) x_q[k] <= x_q[k-1];
        acc_q <= '0;
        tap_q <= '0;
      end
      if (state_q == StMac) begin
        acc_q <= mac_sum;
        tap_q <= tap_q + 1'b1;
      end
      if (mac_last) begin
        fir_out_q   <= mac_sum;
        out_valid_q <= 1'b1;
      end
      if ((state_q == StHold) && out_ready) out_valid_q <= 1'b0;
      // A write in the accepting cycle lands before the first MAC step, so it is used.
      if (coef_we) w_q[coef_addr] <= coef_data;
    end
  end

  assign fir_out   = fir_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);

endmodule
